// File: rtl/commit_checker.sv
// rtl/commit_checker.sv - in-order commit scoreboard: multi-push write FIFO checked against a reference commit stream
//
// Purpose:
//   Collects up to NUM_PORTS register-file writes per cycle into a FIFO.
//   Enabled ports are packed in ascending port order, so port 0 is the oldest.
//   Each buffered write is compared in order against a reference commit
//   stream that arrives over a valid/ready handshake.
//   The block reports saturating match and mismatch counts and captures the
//   first mismatch. It also reports dropped push cycles (overflow) and can halt
//   on the first mismatch.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   dut_we_i/wa_i/wd_i      per-port write enable, key, value (port p at [p*W +: W])
//   ref_valid_i/ready_o     reference commit handshake
//   ref_key_i/value_i       expected key/value for the current head
//   stop_on_mismatch_i      enter HALT on a mismatch
//   clear_i                 synchronous clear of FIFO, counters, flags, state
//   match_count_o           saturating match count
//   mismatch_count_o        saturating mismatch count
//   mismatch_o              one-cycle pulse per mismatch
//   err_valid_o, err_*_o    sticky first-mismatch record
//   overflow_o              sticky; a push cycle was dropped
//   halted_o                checker is in HALT
//   level_o                 FIFO occupancy

module commit_checker #(
  parameter int NUM_PORTS   = 2,
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 128,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             dut_we_i,
  input  logic [NUM_PORTS*KEY_WIDTH-1:0]   dut_wa_i,
  input  logic [NUM_PORTS*VALUE_WIDTH-1:0] dut_wd_i,
  input  logic                             ref_valid_i,
  output logic                             ref_ready_o,
  input  logic [KEY_WIDTH-1:0]             ref_key_i,
  input  logic [VALUE_WIDTH-1:0]           ref_value_i,
  input  logic                             stop_on_mismatch_i,
  input  logic                             clear_i,
  output logic [CNT_WIDTH-1:0]             match_count_o,
  output logic [CNT_WIDTH-1:0]             mismatch_count_o,
  output logic                             mismatch_o,
  output logic                             err_valid_o,
  output logic [KEY_WIDTH-1:0]             err_key_got_o,
  output logic [KEY_WIDTH-1:0]             err_key_exp_o,
  output logic [VALUE_WIDTH-1:0]           err_val_got_o,
  output logic [VALUE_WIDTH-1:0]           err_val_exp_o,
  output logic                             overflow_o,
  output logic                             halted_o,
  output logic [$clog2(DEPTH):0]           level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [CNT_WIDTH-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0]   mism_cnt_q, mism_cnt_d;
  logic                   mismatch_q, mismatch_d;
  logic                   err_valid_q, err_valid_d;
  logic [KEY_WIDTH-1:0]   err_key_got_q, err_key_got_d;
  logic [KEY_WIDTH-1:0]   err_key_exp_q, err_key_exp_d;
  logic [VALUE_WIDTH-1:0] err_val_got_q, err_val_got_d;
  logic [VALUE_WIDTH-1:0] err_val_exp_q, err_val_exp_d;
  logic                   overflow_q, overflow_d;

  // Storage is not reset: the pointers and level define which slots are live.
  logic [KEY_WIDTH-1:0]   key_mem [DEPTH];
  logic [VALUE_WIDTH-1:0] val_mem [DEPTH];

  logic [LVL_W-1:0]       push_cnt;
  logic [LVL_W-1:0]       free_slots;
  logic [PTR_W-1:0]       slot [NUM_PORTS];
  logic                   push_ok;
  logic                   pop;
  logic                   head_match;
  logic [KEY_WIDTH-1:0]   head_key;
  logic [VALUE_WIDTH-1:0] head_val;

  // Compaction: each enabled port lands at wr_ptr plus the number of enabled
  // ports below it. The slot of a disabled port is computed but never written.
  always_comb begin
    push_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot[p]  = wr_ptr_q + PTR_W'(push_cnt);
      push_cnt = push_cnt + LVL_W'(dut_we_i[p]);
    end
  end

  // All-or-nothing push.
  // The check uses the occupancy at the start of the cycle, so a concurrent pop
  // does not make room for the push.
  assign free_slots = LVL_W'(DEPTH) - level_q;
  assign push_ok    = (push_cnt <= free_slots);

  assign head_key   = key_mem[rd_ptr_q];
  assign head_val   = val_mem[rd_ptr_q];
  assign head_match = (head_key == ref_key_i) && (head_val == ref_value_i);

  assign ref_ready_o = (state_q == ST_RUN) && (level_q != '0);
  assign pop         = ref_valid_i && ref_ready_o;

  always_ff @(posedge clk_i) begin
    if (!clear_i && push_ok) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (dut_we_i[p]) begin
          key_mem[slot[p]] <= dut_wa_i[p*KEY_WIDTH +: KEY_WIDTH];
          val_mem[slot[p]] <= dut_wd_i[p*VALUE_WIDTH +: VALUE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    match_cnt_d   = match_cnt_q;
    mism_cnt_d    = mism_cnt_q;
    mismatch_d    = 1'b0;
    err_valid_d   = err_valid_q;
    err_key_got_d = err_key_got_q;
    err_key_exp_d = err_key_exp_q;
    err_val_got_d = err_val_got_q;
    err_val_exp_d = err_val_exp_q;
    overflow_d    = overflow_q;

    if (clear_i) begin
      state_d       = ST_RUN;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      match_cnt_d   = '0;
      mism_cnt_d    = '0;
      err_valid_d   = 1'b0;
      err_key_got_d = '0;
      err_key_exp_d = '0;
      err_val_got_d = '0;
      err_val_exp_d = '0;
      overflow_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
      end else begin
        overflow_d = 1'b1;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      level_d = level_q + (push_ok ? push_cnt : '0) - LVL_W'(pop);

      if (pop) begin
        if (head_match) begin
          if (match_cnt_q != '1) begin
            match_cnt_d = match_cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          mismatch_d = 1'b1;
          if (mism_cnt_q != '1) begin
            mism_cnt_d = mism_cnt_q + CNT_WIDTH'(1);
          end
          if (!err_valid_q) begin
            err_valid_d   = 1'b1;
            err_key_got_d = head_key;
            err_key_exp_d = ref_key_i;
            err_val_got_d = head_val;
            err_val_exp_d = ref_value_i;
          end
          if (stop_on_mismatch_i) begin
            state_d = ST_HALT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      match_cnt_q   <= '0;
      mism_cnt_q    <= '0;
      mismatch_q    <= 1'b0;
      err_valid_q   <= 1'b0;
      err_key_got_q <= '0;
      err_key_exp_q <= '0;
      err_val_got_q <= '0;
      err_val_exp_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      match_cnt_q   <= match_cnt_d;
      mism_cnt_q    <= mism_cnt_d;
      mismatch_q    <= mismatch_d;
      err_valid_q   <= err_valid_d;
      err_key_got_q <= err_key_got_d;
      err_key_exp_q <= err_key_exp_d;
      err_val_got_q <= err_val_got_d;
      err_val_exp_q <= err_val_exp_d;
      overflow_q    <= overflow_d;
    end
  end

  assign match_count_o    = match_cnt_q;
  assign mismatch_count_o = mism_cnt_q;
  assign mismatch_o       = mismatch_q;
  assign err_valid_o      = err_valid_q;
  assign err_key_got_o    = err_key_got_q;
  assign err_key_exp_o    = err_key_exp_q;
  assign err_val_got_o    = err_val_got_q;
  assign err_val_exp_o    = err_val_exp_q;
  assign overflow_o       = overflow_q;
  assign halted_o         = (state_q == ST_HALT);
  assign level_o          = level_q;

endmodule
